// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the program loader.
// The host/bench side uses master; the loader uses slave.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_written;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_hold, load_done, load_error, words_written
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata,
    output cpu_hold, load_done, load_error, words_written
  );
endinterface

// File: rtl/program_loader.sv
// Receives framed bytes (A5, LEN, 4*N little-endian data bytes, XOR checksum), writes the
// words into instruction memory and keeps the CPU in reset until a frame loads cleanly.
module program_loader #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT_CYC   = 1000000,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input logic             MAX10_CLK1_50,
  input logic             reset,
  program_loader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic [ADDR_W:0]   words_written_q, words_written_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_W-9:0] buf_q, buf_d;
  logic [7:0]        chk_q, chk_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              accept;
  logic [ADDR_W:0]   ww_next;

  assign accept  = bus.rx_valid && rx_ready_q;
  assign ww_next = words_written_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d         = state_q;
    rx_ready_d      = 1'b1;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    cpu_hold_d      = cpu_hold_q;
    load_done_d     = load_done_q;
    load_error_d    = load_error_q;
    words_written_d = words_written_q;
    len_d           = len_q;
    byte_cnt_d      = byte_cnt_q;
    buf_d           = buf_q;
    chk_d           = chk_q;
    tmo_d           = tmo_q;

    case (state_q)
      LEN: begin
        if (accept) begin
          len_d           = (bus.rx_data == 8'h00) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(bus.rx_data);
          byte_cnt_d      = 2'd0;
          chk_d           = 8'h00;
          words_written_d = '0;
          cpu_hold_d      = 1'b1;
          load_done_d     = 1'b0;
          load_error_d    = 1'b0;
          state_d         = DATA;
        end
      end
      DATA: begin
        // words_written advances in the write cycle, so it doubles as the next word index
        if (mem_we_q) begin
          words_written_d = ww_next;
          if (ww_next == len_q) state_d = CHK;
        end
        if (accept) begin
          chk_d = chk_q ^ bus.rx_data;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            rx_ready_d  = 1'b0;
            mem_wdata_d = {bus.rx_data, buf_q};
            mem_addr_d  = words_written_q[ADDR_W-1:0];
            byte_cnt_d  = 2'd0;
          end else begin
            buf_d      = {bus.rx_data, buf_q[DATA_W-9:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (bus.rx_data == chk_q) begin
            state_d     = DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = ERR;
            load_error_d = 1'b1;
          end
        end
      end
      default: begin
        if (accept && bus.rx_data == 8'hA5) state_d = LEN;
      end
    endcase

    // Inter-byte watchdog inside a frame; any pending partial word is simply dropped
    if (state_q == LEN || state_q == DATA || state_q == CHK) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d      = ERR;
        load_error_d = 1'b1;
        cpu_hold_d   = 1'b1;
        tmo_d        = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rx_ready_q      <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cpu_hold_q      <= HOLD_AT_RESET;
      load_done_q     <= 1'b0;
      load_error_q    <= 1'b0;
      words_written_q <= '0;
      len_q           <= '0;
      byte_cnt_q      <= 2'd0;
      buf_q           <= '0;
      chk_q           <= 8'h00;
      tmo_q           <= '0;
    end else begin
      state_q         <= state_d;
      rx_ready_q      <= rx_ready_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cpu_hold_q      <= cpu_hold_d;
      load_done_q     <= load_done_d;
      load_error_q    <= load_error_d;
      words_written_q <= words_written_d;
      len_q           <= len_d;
      byte_cnt_q      <= byte_cnt_d;
      buf_q           <= buf_d;
      chk_q           <= chk_d;
      tmo_q           <= tmo_d;
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.cpu_hold      = cpu_hold_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_error    = load_error_q;
  assign bus.words_written = words_written_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frames are queued as bytes, expected memory writes go to a
// scoreboard and are compared against the writes captured from the memory port.
module tb_program_loader;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  program_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  program_loader #(
    .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(TMO), .HOLD_AT_RESET(1'b1)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .bus          (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [39:0] exp_q[$];
  logic [39:0] act_q[$];
  logic [7:0]  tx_q[$];
  bit          chk_ready = 1'b0;
  int          ready_bad = 0;
  int          ready_low = 0;

  localparam logic [53:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 9'h000};

  // Capture every memory write and watch that rx_ready only drops in write cycles
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) act_q.push_back({bus.mem_addr, bus.mem_wdata});
      if (!bus.rx_ready) ready_low++;
      if (chk_ready && (bus.rx_ready === bus.mem_we)) ready_bad++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [53:0] out_vec();
    return {bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.cpu_hold, bus.load_done, bus.load_error, bus.words_written};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic took;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    do begin
      took = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 20);
    if (!took) begin
      fails++;
      $display("[TB] FAIL handshake: byte %h not taken, rx_ready=%b required 1", b, bus.rx_ready);
    end
  endtask

  // Sends the queued bytes with rx_valid held high the whole time
  task automatic send_tx();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    bus.rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Queues a frame; data byte k = seed + 0x11*k. Sends only ndata data bytes and
  // omits the checksum if the frame is truncated. Expected writes optionally queued.
  task automatic add_frame(input int nwords, input logic [7:0] seed, input bit bad_chk,
                           input int ndata, input bit push_exp);
    logic [7:0]  b, chk;
    logic [31:0] w;
    chk = 8'h00;
    w   = 32'h0;
    tx_q.push_back(8'hA5);
    tx_q.push_back(nwords[7:0]);
    for (int k = 0; k < ndata; k++) begin
      b = seed + 8'(8'h11 * k);
      tx_q.push_back(b);
      chk = chk ^ b;
      w[8*(k%4) +: 8] = b;
      if (push_exp && (k % 4) == 3) exp_q.push_back({8'(k / 4), w});
    end
    if (ndata == 4 * nwords) tx_q.push_back(bad_chk ? (chk ^ 8'h88) : chk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++;
      $display("[TB] FAIL reset_values: got %h required %h", out_vec(), RESET_VEC);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.rx_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_reset: got %b required 1", bus.rx_ready);
    end
    tests++;
    if ({bus.mem_we, bus.cpu_hold, bus.load_done, bus.load_error, bus.words_written} !== {4'b0100, 9'h0}) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got %b required %b",
               {bus.mem_we, bus.cpu_hold, bus.load_done, bus.load_error, bus.words_written}, {4'b0100, 9'h0});
    end
    chk_ready = 1'b1;
  endtask

  task automatic test_good_frame();
    logic [39:0] e, a;
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h13);
    send_tx();
    tests++;
    if (act_q.size() != 0 || bus.cpu_hold !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_ignore: writes=%0d hold=%b required 0 writes hold=1", act_q.size(), bus.cpu_hold);
    end
    add_frame(2, 8'h11, 1'b0, 8, 1'b0);
    exp_q.push_back({8'h00, 32'h44332211});
    exp_q.push_back({8'h01, 32'h88776655});
    send_tx();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL good_write: none, required %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin fails++; $display("[TB] FAIL good_write: got %h required %h", a, e); end
      end
    end
    tests++;
    if (act_q.size() != 0) begin fails++; $display("[TB] FAIL good_extra: %0d extra writes, required 0", act_q.size()); end
    tests++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written} !== {3'b100, 9'd2}) begin
      fails++;
      $display("[TB] FAIL good_status: done/err/hold/ww got %b required %b",
               {bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written}, {3'b100, 9'd2});
    end
  endtask

  task automatic test_bad_checksum();
    logic [39:0] e, a;
    add_frame(2, 8'h11, 1'b1, 8, 1'b1);
    send_tx();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL badchk_write: none, required %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin fails++; $display("[TB] FAIL badchk_write: got %h required %h", a, e); end
      end
    end
    tests++;
    if (act_q.size() != 0) begin fails++; $display("[TB] FAIL badchk_extra: %0d extra writes, required 0", act_q.size()); end
    tests++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written} !== {3'b011, 9'd2}) begin
      fails++;
      $display("[TB] FAIL badchk_status: done/err/hold/ww got %b required %b",
               {bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written}, {3'b011, 9'd2});
    end
  endtask

  task automatic test_full_frame();
    logic [39:0] e, a;
    int low0, nerr;
    low0 = ready_low;
    nerr = 0;
    add_frame(256, 8'h07, 1'b0, 1024, 1'b1);
    send_tx();
    tests++;
    if (act_q.size() != 256) begin
      fails++;
      $display("[TB] FAIL full_count: got %0d writes required 256", act_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL full_write: none, required %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          fails++;
          if (nerr++ < 8) $display("[TB] FAIL full_write: got %h required %h", a, e);
        end
      end
    end
    tests++;
    if (act_q.size() != 0) begin fails++; $display("[TB] FAIL full_extra: %0d extra writes, required 0", act_q.size()); end
    tests++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written} !== {3'b100, 9'd256}) begin
      fails++;
      $display("[TB] FAIL full_status: done/err/hold/ww got %b required %b",
               {bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written}, {3'b100, 9'd256});
    end
    tests++;
    if (ready_low - low0 != 256 || ready_bad != 0) begin
      fails++;
      $display("[TB] FAIL back_to_back_ready: low cycles %0d (required 256), misaligned %0d (required 0)",
               ready_low - low0, ready_bad);
    end
  endtask

  task automatic test_timeout();
    logic [39:0] e, a;
    int n;
    add_frame(2, 8'h31, 1'b0, 6, 1'b1);
    bus.rx_data = 8'h00;
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    bus.rx_valid = 1'b0;
    n = 0;
    while (bus.load_error !== 1'b1 && n < TMO + 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (bus.load_error !== 1'b1 || n < TMO - 2 || n > TMO + 2) begin
      fails++;
      $display("[TB] FAIL timeout_abort: load_error=%b after %0d idle cycles, required 1 after ~%0d",
               bus.load_error, n, TMO);
    end
    repeat (2 * TMO) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL timeout_write: none, required %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin fails++; $display("[TB] FAIL timeout_write: got %h required %h", a, e); end
      end
    end
    tests++;
    if (act_q.size() != 0) begin fails++; $display("[TB] FAIL timeout_extra: %0d extra writes, required 0", act_q.size()); end
    tests++;
    if ({bus.load_done, bus.cpu_hold, bus.words_written} !== {2'b01, 9'd1}) begin
      fails++;
      $display("[TB] FAIL timeout_status: done/hold/ww got %b required %b",
               {bus.load_done, bus.cpu_hold, bus.words_written}, {2'b01, 9'd1});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] e, a;
    add_frame(4, 8'h5A, 1'b0, 10, 1'b1);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    bus.rx_valid = 1'b0;
    chk_ready = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++;
      $display("[TB] FAIL midreset_async: got %h required %h", out_vec(), RESET_VEC);
    end
    @(posedge clk); #1;
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++;
      $display("[TB] FAIL midreset_edge: got %h required %h", out_vec(), RESET_VEC);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk_ready = 1'b1;
    add_frame(4, 8'h23, 1'b0, 16, 1'b1);
    send_tx();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL midreset_write: none, required %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin fails++; $display("[TB] FAIL midreset_write: got %h required %h", a, e); end
      end
    end
    tests++;
    if (act_q.size() != 0) begin fails++; $display("[TB] FAIL midreset_extra: %0d extra writes, required 0", act_q.size()); end
    tests++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written} !== {3'b100, 9'd4}) begin
      fails++;
      $display("[TB] FAIL midreset_reload: done/err/hold/ww got %b required %b",
               {bus.load_done, bus.load_error, bus.cpu_hold, bus.words_written}, {3'b100, 9'd4});
    end
    tests++;
    if (ready_bad != 0) begin
      fails++;
      $display("[TB] FAIL ready_alignment: %0d misaligned rx_ready cycles, required 0", ready_bad);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_full_frame();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
